lsu_byte_bus: RTL and testbench
===============================

Name: lsu_byte_bus

Overview:
- Load/store responder for the data-memory control produced by decode: mem_wr_en, mem_size_sel, mem_sign_extend, plus ALU result as address.
- Executes one load or store per request by serialising it into byte beats on an 8-bit req/ack memory bus, little-endian.
- Returns extended load data to the RF write-back mux (RF_DATA_IN_MUX_SEL = 2'b10 path).
- Sits between the execute stage and the byte-wide data memory.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles a beat waits for bus_ack before abort; 0 disables the timeout.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  access request
- req_ready  output  1  high only in IDLE
- addr  input  32  byte address of first byte
- mem_wr_en  input  1  1 = store, 0 = load
- mem_size_sel  input  2  0 = byte, 1 = half, 3 = word, 2 = treated as word
- mem_sign_extend  input  1  decode encoding: 1 = zero-extend (LBU/LHU), 0 = sign-extend; ignored for stores and words
- wdata  input  32  store data
- rdata  output  32  extended load result
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle timeout-abort pulse
- busy  output  1  high in ACCESS
- bus_req  output  1  beat request
- bus_we  output  1  beat is a write
- bus_addr  output  32  beat byte address
- bus_wdata  output  8  beat write byte
- bus_ack  input  1  beat complete; sampled at rising edge while bus_req = 1
- bus_rdata  input  8  read byte, valid with bus_ack

Behaviour:
- Clock/reset decided: one clock `clock`; reset `reset_n` asynchronous, active-low.
- Reset values: state IDLE; req_ready 1; busy, done, err, bus_req, bus_we 0; rdata, bus_addr, bus_wdata, beat counter, timeout counter 0.
- FSM has three states: IDLE, ACCESS, FINISH.
- IDLE: on an edge with req_valid && req_ready:
  - latch addr, op, size, extend flag, wdata;
  - set beats N = 1, 2 or 4 (size 0, 1, 3/2) and beat index i = 0;
  - clear rdata;
  - go to ACCESS.
- ACCESS: bus_req = 1, bus_we = latched op, bus_addr = addr + i (32-bit modular, 0xFFFFFFFF wraps to 0), bus_wdata = wdata[8i+7:8i].
- ACCESS, edge with bus_ack = 1:
  - on a load, rdata[8i+7:8i] <= bus_rdata;
  - i increments and the timeout counter clears;
  - bus_req stays high and the next beat's addr/wdata appear the following cycle;
  - after beat N-1, go to FINISH and drop bus_req.
- ACCESS, edge with bus_ack = 0: timeout counter increments.
- Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to FINISH with the abort flag set.
- FINISH (exactly one cycle):
  - normal completion: done = 1;
  - abort: err = 1 and done = 0;
  - then return to IDLE.
- Load extension is applied when entering FINISH:
  - byte: bits 31:8 = mem_sign_extend ? 0 : rdata[7];
  - half: bits 31:16 = mem_sign_extend ? 0 : rdata[15];
  - word: unchanged.
- rdata holds until the next request is accepted. On a store it reads 0. On abort it is 0.
- Latency with bus_ack tied high: acceptance edge E0; beats complete at E1..EN; done high in the cycle after EN. Back-to-back throughput is N + 2 cycles per access.
- busy = (state == ACCESS). req_ready = (state == IDLE).
- bus_ack while bus_req = 0 is ignored.
- req_valid outside IDLE is ignored; the requester must hold it.
- No alignment restriction: misaligned half/word accesses are serialised normally.
- Reset mid-access: immediate return to reset values; bus_req drops asynchronously. Bytes already written are not rolled back.
- A second access is never started while a prior request's done/err pulse is high.

Decomposition:
- Shared package holds:
  - size encodings MEM_SIZE_BYTE = 2'd0, MEM_SIZE_HALF = 2'd1, MEM_SIZE_WORD = 2'd3;
  - FSM state encodings LSU_IDLE, LSU_ACCESS, LSU_FINISH;
  - the decode-side meaning of mem_sign_extend (1 = zero-extend).
- One sub-module, lsu_load_extend: combinational size/extend of the assembled 32-bit word. It is reused later by any wider-bus LSU.

Test Plan:
- LB sign, ack tied high: addr 0x100, size 0, ext 0, memory[0x100] = 0x85 -> one beat at 0x100, done in the 2nd cycle after acceptance, rdata = 0xFFFFFF85.
- LHU: addr 0x202, size 1, ext 1, bytes 0x34, 0x F2 at 0x202/0x203 -> beats at 0x202 then 0x203, rdata = 0x0000F234. The same with ext 0 -> 0xFFFFF234.
- SW misaligned with wrap: addr 0xFFFFFFFE, wdata 0xDEADBEEF, size 3 -> writes EF@0xFFFFFFFE, BE@0xFFFFFFFF, AD@0x0, DE@0x1, done pulse 1 cycle, rdata = 0.
- Stalled ack: LW with ack delayed 3 cycles per beat, TIMEOUT_CYCLES = 16 -> bus_addr/bus_req stable during stalls, done 17 cycles after acceptance, correct word.
- Timeout: ack never asserted, TIMEOUT_CYCLES = 4 -> bus_req high 4 cycles, then err = 1 for one cycle, done = 0, rdata = 0, req_ready = 1 next cycle.
- Reset mid-access: reset_n low during beat 2 of a word store -> bus_req, busy 0 immediately; after release, req_ready = 1; a new LB completes normally.

Source files
------------

// File: rtl/lsu_byte_bus_pkg.sv
// Shared encodings for the byte-serial load/store unit: access sizes,
// FSM states and the decode-side meaning of the extend flag.
package lsu_byte_bus_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd3;

   // Decode drives mem_sign_extend = 1 for LBU/LHU, i.e. the flag means zero-extend.
   localparam logic EXT_ZERO_EXTEND = 1'b1;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_FINISH = 2'd2
   } lsu_state_t;

   // Index of the final byte beat; size 2 is handled as a word.
   function automatic logic [1:0] lsu_last_beat(input logic [1:0] size);
      case (size)
         MEM_SIZE_BYTE: return 2'd0;
         MEM_SIZE_HALF: return 2'd1;
         default:       return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_bus_load_extend.sv
// Combinational size/extend of an assembled little-endian load word.
module lsu_load_extend
   import lsu_byte_bus_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_size,
   input  logic        i_zero_ext,
   output logic [31:0] o_data
);

   logic w_fill_b;
   logic w_fill_h;

   assign w_fill_b = (i_zero_ext == EXT_ZERO_EXTEND) ? 1'b0 : i_data[7];
   assign w_fill_h = (i_zero_ext == EXT_ZERO_EXTEND) ? 1'b0 : i_data[15];

   always_comb begin
      o_data = i_data;
      case (i_size)
         MEM_SIZE_BYTE: o_data = {{24{w_fill_b}}, i_data[7:0]};
         MEM_SIZE_HALF: o_data = {{16{w_fill_h}}, i_data[15:0]};
         default:       o_data = i_data;
      endcase
   end

endmodule

// File: rtl/lsu_byte_bus.sv
// Load/store responder: serialises one byte/half/word access into
// little-endian byte beats on a req/ack bus and returns extended load data.
module lsu_byte_bus
   import lsu_byte_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_addr,
   input  logic        i_mem_wr_en,
   input  logic [1:0]  i_mem_size_sel,
   input  logic        i_mem_sign_extend,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_done,
   output logic        o_err,
   output logic        o_busy,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [7:0]  o_bus_wdata,
   input  logic        i_bus_ack,
   input  logic [7:0]  i_bus_rdata
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   lsu_state_t    r_state;
   logic [31:0]   r_addr;
   logic          r_we;
   logic [1:0]    r_size;
   logic          r_zext;
   logic [31:0]   r_wdata;
   logic [1:0]    r_idx;
   logic [1:0]    r_last;
   logic [TW-1:0] r_tmo;
   logic [31:0]   r_rdata;
   logic          r_done;
   logic          r_err;

   logic          w_busy;
   logic [31:0]   w_merged;
   logic [31:0]   w_ext;
   logic [7:0]    w_wbyte;

   assign w_busy      = (r_state == LSU_ACCESS);
   assign w_wbyte     = r_wdata[{r_idx, 3'b000} +: 8];
   assign o_busy      = w_busy;
   assign o_req_ready = (r_state == LSU_IDLE);
   assign o_bus_req   = w_busy;
   assign o_bus_we    = w_busy & r_we;
   assign o_bus_addr  = w_busy ? (r_addr + {30'd0, r_idx}) : 32'd0;
   assign o_bus_wdata = w_busy ? w_wbyte : 8'd0;
   assign o_rdata     = r_rdata;
   assign o_done      = r_done;
   assign o_err       = r_err;

   // Load word with the byte arriving this cycle already merged in, so the
   // final beat can be extended on the same edge that enters FINISH.
   always_comb begin
      w_merged = r_rdata;
      w_merged[{r_idx, 3'b000} +: 8] = i_bus_rdata;
   end

   lsu_load_extend u_extend (
      .i_data     (w_merged),
      .i_size     (r_size),
      .i_zero_ext (r_zext),
      .o_data     (w_ext)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= LSU_IDLE;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_size  <= MEM_SIZE_BYTE;
         r_zext  <= 1'b0;
         r_wdata <= '0;
         r_idx   <= '0;
         r_last  <= '0;
         r_tmo   <= '0;
         r_rdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            LSU_IDLE: begin
               if (i_req_valid) begin
                  r_addr  <= i_addr;
                  r_we    <= i_mem_wr_en;
                  r_size  <= i_mem_size_sel;
                  r_zext  <= i_mem_sign_extend;
                  r_wdata <= i_wdata;
                  r_last  <= lsu_last_beat(i_mem_size_sel);
                  r_idx   <= '0;
                  r_tmo   <= '0;
                  r_rdata <= '0;
                  r_state <= LSU_ACCESS;
               end
            end
            LSU_ACCESS: begin
               if (i_bus_ack) begin
                  r_tmo <= '0;
                  if (r_idx == r_last) begin
                     if (!r_we) r_rdata <= w_ext;
                     r_done  <= 1'b1;
                     r_state <= LSU_FINISH;
                  end else begin
                     if (!r_we) r_rdata <= w_merged;
                     r_idx <= r_idx + 2'd1;
                  end
               end else if (TIMEOUT_CYCLES != 0) begin
                  // Abort on the edge that would bring the stall count to the limit.
                  if (r_tmo == TMO_LAST) begin
                     r_tmo   <= '0;
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                     r_state <= LSU_FINISH;
                  end else begin
                     r_tmo <= r_tmo + TW'(1);
                  end
               end
            end
            LSU_FINISH: r_state <= LSU_IDLE;
            default:    r_state <= LSU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_bus.sv
// Self-checking bench for lsu_byte_bus: directed cases plus randomized
// accesses checked against a byte-addressed memory model.
module tb_lsu_byte_bus;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] addr = '0;
   logic        mem_wr_en = 1'b0;
   logic [1:0]  mem_size_sel = '0;
   logic        mem_sign_extend = 1'b0;
   logic [31:0] wdata = '0;
   logic        bus_ack = 1'b0;
   logic [7:0]  bus_rdata = '0;

   logic        req_ready;
   logic [31:0] rdata;
   logic        done;
   logic        err;
   logic        busy;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [7:0]  bus_wdata;

   int n_checks = 0;
   int n_pass = 0;
   int n_txn = 0;

   logic [7:0] mem [logic [31:0]];

   always #5 clock = ~clock;

   lsu_byte_bus #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clock           (clock),
      .i_reset_n         (reset_n),
      .i_req_valid       (req_valid),
      .o_req_ready       (req_ready),
      .i_addr            (addr),
      .i_mem_wr_en       (mem_wr_en),
      .i_mem_size_sel    (mem_size_sel),
      .i_mem_sign_extend (mem_sign_extend),
      .i_wdata           (wdata),
      .o_rdata           (rdata),
      .o_done            (done),
      .o_err             (err),
      .o_busy            (busy),
      .o_bus_req         (bus_req),
      .o_bus_we          (bus_we),
      .o_bus_addr        (bus_addr),
      .o_bus_wdata       (bus_wdata),
      .i_bus_ack         (bus_ack),
      .i_bus_rdata       (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'hA5;
   endfunction

   // One complete access; stall < 0 picks a random 0..3 ack delay per beat.
   task automatic access(input logic we, input logic [1:0] size, input logic zext,
                         input logic [31:0] a, input logic [31:0] wd, input int stall);
      int          nb;
      int          st;
      logic [31:0] val;
      logic [31:0] exp_rd;
      logic [31:0] ba;
      logic [7:0]  wb;
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      val = '0;
      check("ready_before", req_ready, 1);
      req_valid = 1'b1; addr = a; mem_wr_en = we; mem_size_sel = size;
      mem_sign_extend = zext; wdata = wd;
      @(negedge clock);
      req_valid = 1'b0; addr = $urandom; wdata = $urandom;
      for (int b = 0; b < nb; b++) begin
         ba = a + 32'(b);
         wb = wd[8*b +: 8];
         st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         for (int s = 0; s <= st; s++) begin
            check("bus_req", bus_req, 1);
            check("busy", busy, 1);
            check("bus_addr", bus_addr, ba);
            check("bus_we", bus_we, we);
            if (we) check("bus_wdata", bus_wdata, wb);
            check("done_early", done, 0);
            if (s == st) begin
               bus_ack = 1'b1;
               if (we) mem[ba] = wb;
               else begin
                  bus_rdata = mem_rd(ba);
                  val = val | (32'(bus_rdata) << (8 * b));
               end
            end else begin
               bus_ack = 1'b0;
               bus_rdata = $urandom;
            end
            @(negedge clock);
            bus_ack = 1'b0;
            bus_rdata = $urandom;
         end
      end
      exp_rd = '0;
      if (!we) begin
         exp_rd = val;
         if (nb == 1 && !zext && val >= 32'd128)   exp_rd = val + 32'hFFFF_FF00;
         if (nb == 2 && !zext && val >= 32'd32768) exp_rd = val + 32'hFFFF_0000;
      end
      check("done", done, 1);
      check("err_clear", err, 0);
      check("bus_req_drop", bus_req, 0);
      check("busy_drop", busy, 0);
      check("rdata", rdata, exp_rd);
      @(negedge clock);
      check("done_pulse", done, 0);
      check("ready_after", req_ready, 1);
      check("rdata_hold", rdata, exp_rd);
      n_txn++;
      $display("txn %0d: %s size=%0d zext=%0d addr=%h wdata=%h rdata=%h exp=%h",
               n_txn, we ? "ST" : "LD", size, zext, a, wd, rdata, exp_rd);
   endtask

   initial begin
      logic [31:0] ra;
      // Reset
      #1 reset_n = 1'b0;
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Ack while idle is ignored
      bus_ack = 1'b1; bus_rdata = 8'h77;
      @(negedge clock);
      bus_ack = 1'b0;
      check("idle_ack_ready", req_ready, 1);
      check("idle_ack_busy", busy, 0);
      check("idle_ack_rdata", rdata, 0);

      // LB sign-extend, ack tied high
      mem[32'h100] = 8'h85;
      access(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 0);
      check("lb_const", rdata, 32'hFFFF_FF85);

      // LHU / LH
      mem[32'h202] = 8'h34; mem[32'h203] = 8'hF2;
      access(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 0);
      check("lhu_const", rdata, 32'h0000_F234);
      access(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 0);
      check("lh_const", rdata, 32'hFFFF_F234);

      // SW misaligned, address wrap
      access(1'b1, 2'd3, 1'b0, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 0);
      check("sw_rdata0", rdata, 0);

      // LW with 3-cycle stalls per beat reads the stored word back
      access(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFE, 32'h0, 3);
      check("lw_stall_const", rdata, 32'hDEAD_BEEF);

      // Size 2 behaves as a word
      access(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0, 1);
      check("size2_const", rdata, 32'hDEAD_BEEF);

      // Timeout: ack never comes
      req_valid = 1'b1; addr = 32'h500; mem_wr_en = 1'b0; mem_size_sel = 2'd3;
      mem_sign_extend = 1'b0;
      @(negedge clock);
      req_valid = 1'b0;
      for (int c = 0; c < TMO; c++) begin
         check("tmo_bus_req", bus_req, 1);
         check("tmo_bus_addr", bus_addr, 32'h500);
         check("tmo_err_early", err, 0);
         @(negedge clock);
      end
      check("tmo_err", err, 1);
      check("tmo_done", done, 0);
      check("tmo_rdata", rdata, 0);
      check("tmo_bus_req_drop", bus_req, 0);
      @(negedge clock);
      check("tmo_err_pulse", err, 0);
      check("tmo_ready", req_ready, 1);
      $display("txn timeout: LD addr=00000500 err observed after %0d stall cycles", TMO);

      // Reset during beat 2 of a word store
      req_valid = 1'b1; addr = 32'h40; mem_wr_en = 1'b1; mem_size_sel = 2'd3;
      wdata = 32'h1122_3344;
      @(negedge clock);
      req_valid = 1'b0;
      bus_ack = 1'b1; mem[32'h40] = 8'h44;
      @(negedge clock);
      bus_ack = 1'b0;
      check("rst_mid_addr", bus_addr, 32'h41);
      #1 reset_n = 1'b0;
      #1;
      check("rst_mid_bus_req", bus_req, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_mid_ready", req_ready, 1);
      $display("txn reset: ST addr=00000040 aborted by reset in beat 2");
      access(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 0);
      check("rst_mid_lbu", rdata, 32'h0000_0044);

      // Randomized accesses against the memory model
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 2))
            0:       ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            1:       ra = 32'h300 + 32'($urandom_range(0, 15));
            default: ra = $urandom;
         endcase
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ra, $urandom, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
